// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID/EX hazard and stall sequencer (load-use, branch flush, MUL/DIV hold)
//
// Purpose: detects load-use hazards that forwarding cannot cover, flushes wrong-path
// instructions on a taken branch, and holds the pipeline while a multi-cycle MUL/DIV
// occupies EX. Keeps a saturating count of PC-stall cycles.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   id_valid          ID holds a valid instruction
//   id_rs1, id_rs2    ID source registers
//   ex_memRead        EX instruction is a load
//   ex_RegAdd         EX destination register
//   ex_muldiv_start   EX holds a MUL/DIV op (held high while the op is held)
//   ex_branch_taken   EX resolved a taken branch/jump this cycle
//   pc_stall, ifid_stall, idex_stall     hold controls
//   ifid_flush, idex_bubble, exmem_bubble  NOP insertion controls
//   md_done           one-cycle pulse, MUL/DIV result valid in EX
//   md_busy           sequencer is in MD_BUSY
//   stall_cycles      saturating count of cycles with pc_stall=1
module hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_RegAdd,
  input  logic             ex_muldiv_start,
  input  logic             ex_branch_taken,
  output logic             pc_stall,
  output logic             ifid_stall,
  output logic             ifid_flush,
  output logic             idex_stall,
  output logic             idex_bubble,
  output logic             exmem_bubble,
  output logic             md_done,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int CW = $clog2(MULDIV_LAT) + 1;
  // Start cycle is the first of MULDIV_LAT cycles; BUSY counts down to 0 for the last one.
  localparam logic [CW-1:0] CNT_INIT = CW'((MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0);

  typedef enum logic {IDLE, MD_BUSY} state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_next_cnt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_load_use;
  logic w_pc_stall, w_ifid_stall, w_ifid_flush, w_idex_stall;
  logic w_idex_bubble, w_exmem_bubble, w_md_done, w_md_busy;

  assign w_load_use = id_valid && ex_memRead && (ex_RegAdd != 5'd0) &&
                      ((ex_RegAdd == id_rs1) || (ex_RegAdd == id_rs2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_next_cnt;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_next_cnt     = r_cnt;
    w_pc_stall     = 1'b0;
    w_ifid_stall   = 1'b0;
    w_ifid_flush   = 1'b0;
    w_idex_stall   = 1'b0;
    w_idex_bubble  = 1'b0;
    w_exmem_bubble = 1'b0;
    w_md_done      = 1'b0;
    w_md_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (ex_branch_taken) begin
          w_ifid_flush  = 1'b1;
          w_idex_bubble = 1'b1;
        end else if (ex_muldiv_start) begin
          if (MULDIV_LAT > 1) begin
            w_pc_stall     = 1'b1;
            w_ifid_stall   = 1'b1;
            w_idex_stall   = 1'b1;
            w_exmem_bubble = 1'b1;
            w_next_state   = MD_BUSY;
            w_next_cnt     = CNT_INIT;
          end else begin
            w_md_done = 1'b1;
          end
        end else if (w_load_use) begin
          // Bubble evicts the load from EX, so the hazard clears by itself next cycle.
          w_pc_stall    = 1'b1;
          w_ifid_stall  = 1'b1;
          w_idex_bubble = 1'b1;
        end
      end
      MD_BUSY: begin
        // ex_muldiv_start is the same op still held; EX holds a non-load, so no load-use.
        w_md_busy = 1'b1;
        if (r_cnt != '0) begin
          w_pc_stall     = 1'b1;
          w_ifid_stall   = 1'b1;
          w_idex_stall   = 1'b1;
          w_exmem_bubble = 1'b1;
          w_next_cnt     = r_cnt - 1'b1;
        end else begin
          w_md_done    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Outputs are forced low for the whole time reset is asserted.
  assign pc_stall     = rst_n & w_pc_stall;
  assign ifid_stall   = rst_n & w_ifid_stall;
  assign ifid_flush   = rst_n & w_ifid_flush;
  assign idex_stall   = rst_n & w_idex_stall;
  assign idex_bubble  = rst_n & w_idex_bubble;
  assign exmem_bubble = rst_n & w_exmem_bubble;
  assign md_done      = rst_n & w_md_done;
  assign md_busy      = rst_n & w_md_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
    end else if (w_pc_stall && (r_stall_cycles != {CNT_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign stall_cycles = r_stall_cycles;

  a_no_start_with_branch: assert property (@(posedge clk) disable iff (!rst_n)
    !(ex_muldiv_start && ex_branch_taken));
  a_no_branch_in_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !((r_state == MD_BUSY) && ex_branch_taken));

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl (LAT=4/CNT_W=32 and LAT=1/CNT_W=4)
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid;
  logic [4:0] id_rs1, id_rs2, ex_RegAdd;
  logic       ex_memRead, ex_muldiv_start, ex_branch_taken;

  logic        a_pc, a_ifs, a_iff, a_ids, a_idb, a_exb, a_done, a_busy;
  logic [31:0] a_cnt;
  logic        b_pc, b_ifs, b_iff, b_ids, b_idb, b_exb, b_done, b_busy;
  logic [3:0]  b_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(32)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memRead(ex_memRead), .ex_RegAdd(ex_RegAdd), .ex_muldiv_start(ex_muldiv_start),
    .ex_branch_taken(ex_branch_taken), .pc_stall(a_pc), .ifid_stall(a_ifs),
    .ifid_flush(a_iff), .idex_stall(a_ids), .idex_bubble(a_idb), .exmem_bubble(a_exb),
    .md_done(a_done), .md_busy(a_busy), .stall_cycles(a_cnt));

  hazard_ctrl #(.MULDIV_LAT(1), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_memRead(ex_memRead), .ex_RegAdd(ex_RegAdd), .ex_muldiv_start(ex_muldiv_start),
    .ex_branch_taken(ex_branch_taken), .pc_stall(b_pc), .ifid_stall(b_ifs),
    .ifid_flush(b_iff), .idex_stall(b_ids), .idex_bubble(b_idb), .exmem_bubble(b_exb),
    .md_done(b_done), .md_busy(b_busy), .stall_cycles(b_cnt));

  // Control vector order: {pc_stall, ifid_stall, ifid_flush, idex_stall,
  //                        idex_bubble, exmem_bubble, md_done, md_busy}
  localparam logic [7:0] NONE = 8'b0000_0000;
  localparam logic [7:0] LU   = 8'b1100_1000;
  localparam logic [7:0] BR   = 8'b0010_1000;
  localparam logic [7:0] MS0  = 8'b1101_0100;
  localparam logic [7:0] MSB  = 8'b1101_0101;
  localparam logic [7:0] MDN  = 8'b0000_0011;
  localparam logic [7:0] BDN  = 8'b0000_0010;

  typedef struct {
    logic       rstn;
    logic       idv;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       mr;
    logic [4:0] rd;
    logic       md;
    logic       br;
    logic [7:0] expa;
    logic [7:0] expb;
  } vec_t;

  typedef struct {
    string       nm;
    logic [7:0]  expa;
    logic [7:0]  expb;
    logic [31:0] cnta;
    logic [3:0]  cntb;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [31:0] m_a   = 0;
  logic [3:0]  m_b   = 0;
  vec_t        tbl[9];

  function automatic vec_t mk(input logic rstn, input logic idv, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic mr, input logic [4:0] rd,
                              input logic md, input logic br, input logic [7:0] ea,
                              input logic [7:0] eb);
    vec_t v;
    v.rstn = rstn; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2; v.mr = mr; v.rd = rd;
    v.md = md; v.br = br; v.expa = ea; v.expb = eb;
    return v;
  endfunction

  function automatic vec_t mdv(input logic md, input logic [7:0] ea, input logic [7:0] eb);
    return mk(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, md, 1'b0, ea, eb);
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", what, act, req);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = v.rstn; id_valid = v.idv; id_rs1 = v.rs1; id_rs2 = v.rs2;
    ex_memRead = v.mr; ex_RegAdd = v.rd; ex_muldiv_start = v.md; ex_branch_taken = v.br;
    if (!v.rstn) begin
      m_a = 0;
      m_b = 0;
    end
    e.nm = nm; e.expa = v.expa; e.expb = v.expb; e.cnta = m_a; e.cntb = m_b;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    check({e.nm, " a_ctrl"}, {24'd0, a_pc, a_ifs, a_iff, a_ids, a_idb, a_exb, a_done, a_busy},
          {24'd0, e.expa});
    check({e.nm, " a_cnt"}, a_cnt, e.cnta);
    check({e.nm, " b_ctrl"}, {24'd0, b_pc, b_ifs, b_iff, b_ids, b_idb, b_exb, b_done, b_busy},
          {24'd0, e.expb});
    check({e.nm, " b_cnt"}, {28'd0, b_cnt}, {28'd0, e.cntb});
    if (v.rstn && v.expa[7]) m_a = m_a + 1;
    if (v.rstn && v.expb[7] && m_b != 4'hF) m_b = m_b + 1;
  endtask

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0;
    ex_memRead = 1'b0; ex_RegAdd = '0; ex_muldiv_start = 1'b0; ex_branch_taken = 1'b0;

    tbl[0] = mk(1, 1, 5'd1, 5'd5, 1, 5'd5, 0, 0, LU, LU);     // match on rs2
    tbl[1] = mk(1, 1, 5'd7, 5'd3, 1, 5'd7, 0, 0, LU, LU);     // match on rs1
    tbl[2] = mk(1, 1, 5'd0, 5'd0, 1, 5'd0, 0, 0, NONE, NONE); // x0 never hazards
    tbl[3] = mk(1, 0, 5'd5, 5'd5, 1, 5'd5, 0, 0, NONE, NONE); // ID not valid
    tbl[4] = mk(1, 1, 5'd5, 5'd5, 0, 5'd5, 0, 0, NONE, NONE); // EX not a load
    tbl[5] = mk(1, 1, 5'd4, 5'd6, 1, 5'd5, 0, 0, NONE, NONE); // no register match
    tbl[6] = mk(1, 1, 5'd1, 5'd5, 1, 5'd5, 0, 1, BR, BR);     // branch beats load-use
    tbl[7] = mk(1, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, BR, BR);     // plain taken branch
    tbl[8] = mk(1, 1, 5'd31, 5'd2, 1, 5'd31, 0, 0, LU, LU);   // top register

    step(mk(0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE), "reset");
    step(mk(0, 1, 5'd5, 5'd5, 1, 5'd5, 0, 0, NONE, NONE), "reset_masks");
    for (int i = 0; i < 9; i++) step(tbl[i], $sformatf("tbl%0d", i));

    // Single MUL/DIV op held for 4 cycles.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE), "rst_md1");
    step(mdv(1, MS0, BDN), "md1_c0");
    step(mdv(1, MSB, BDN), "md1_c1");
    step(mdv(1, MSB, BDN), "md1_c2");
    step(mdv(1, MDN, BDN), "md1_c3");
    step(mdv(0, NONE, NONE), "md1_c4");
    check("md1_total", a_cnt, 32'd3);

    // Back-to-back ops: second start the cycle after md_done.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE), "rst_md2");
    for (int k = 0; k < 2; k++) begin
      step(mdv(1, MS0, BDN), "b2b_c0");
      step(mdv(1, MSB, BDN), "b2b_c1");
      step(mdv(1, MSB, BDN), "b2b_c2");
      step(mdv(1, MDN, BDN), "b2b_c3");
    end
    step(mdv(0, NONE, NONE), "b2b_end");
    check("b2b_total", a_cnt, 32'd6);

    // Reset while BUSY with cnt=1 aborts without md_done.
    step(mdv(1, MS0, BDN), "abort_c0");
    step(mdv(1, MSB, BDN), "abort_c1");
    step(mk(0, 0, 0, 0, 0, 0, 1, 0, NONE, NONE), "abort_rst");
    step(mdv(0, NONE, NONE), "abort_idle");
    step(mdv(0, NONE, NONE), "abort_idle2");

    // Continuous load-use stalls drive the 4-bit counter into saturation.
    step(mk(0, 0, 0, 0, 0, 0, 0, 0, NONE, NONE), "rst_sat");
    for (int i = 0; i < 20; i++) step(tbl[0], $sformatf("sat%0d", i));
    step(tbl[2], "sat_end");
    check("sat_b", {28'd0, b_cnt}, 32'd15);
    check("sat_a", a_cnt, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
